// File: rtl/gaussian_smoother_pkg.sv
// Shared constants for the 3x3 Gaussian smoother: kernel weights, sum width,
// rounding offset and FSM state encoding.
package gaussian_smoother_pkg;

   localparam int SUM_W = 12;
   localparam int ROUND = 8;
   localparam int NORM_SHIFT = 4;

   localparam int unsigned K_WEIGHT [3][3] = '{'{1, 2, 1},
                                               '{2, 4, 2},
                                               '{1, 2, 1}};

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      FLUSH,
      DONE
   } state_t;

endpackage

// File: rtl/gaussian_smoother_if.sv
// Pixel stream bundle between the upstream source and the smoother; the
// smoother is the slave side.
interface gaussian_smoother_if #(
   parameter int DATA_W = 8
) ();

   logic              enb;
   logic [DATA_W-1:0] pixel_in;
   logic [DATA_W-1:0] pixel_out;
   logic              out_valid;
   logic              frame_done;

   modport master (
      output enb, pixel_in,
      input  pixel_out, out_valid, frame_done
   );

   modport slave (
      input  enb, pixel_in,
      output pixel_out, out_valid, frame_done
   );

endinterface

// File: rtl/smoother_line_buffer.sv
// Fixed-length delay line: dout is the sample written DEPTH shifts ago.
module smoother_line_buffer #(
   parameter int DEPTH  = 128,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;

   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (shift) begin
         ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      end
   end

   // NOTE: the storage array has no reset; its stale contents only ever reach
   // border positions, which bypass the kernel, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (shift) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/gaussian_smoother.sv
// Streaming 3x3 Gaussian smoother: two cascaded line buffers feed a 3x3 window;
// borders pass the centre pixel through, interior pixels get the rounded kernel sum.
module gaussian_smoother
   import gaussian_smoother_pkg::*;
#(
   parameter int IMG_WIDTH  = 128,
   parameter int IMG_HEIGHT = 128,
   parameter int DATA_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   gaussian_smoother_if.slave   bus
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

   state_t            state;
   logic [COL_W-1:0]  in_col, out_col;
   logic [ROW_W-1:0]  in_row, out_row;
   logic [DATA_W-1:0] win [3][3];
   logic [DATA_W-1:0] nw  [3][3];
   logic [DATA_W-1:0] din, lb1_q, lb2_q;
   logic [DATA_W-1:0] result;
   logic [SUM_W-1:0]  sum;
   logic              accept, shift, emit, border;

   assign accept = bus.enb && (state == IDLE || state == FILL || state == RUN);
   assign shift  = accept || (state == FLUSH);
   assign emit   = (accept && state == RUN) || (state == FLUSH);
   assign din    = (state == FLUSH) ? '0 : bus.pixel_in;
   assign border = (out_row == '0) || (out_row == LAST_ROW) ||
                   (out_col == '0) || (out_col == LAST_COL);

   smoother_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
      .clk(clk), .reset(reset), .shift(shift), .din(din), .dout(lb1_q)
   );

   smoother_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb2 (
      .clk(clk), .reset(reset), .shift(shift), .din(lb1_q), .dout(lb2_q)
   );

   // Window as it will look after this shift; the output register samples it
   // directly so a result appears one clock after the accepting edge.
   // NOTE: every always_comb output is assigned on every path so no latch is inferred.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nw[i][0] = win[i][1];
         nw[i][1] = win[i][2];
      end
      nw[0][2] = lb2_q;
      nw[1][2] = lb1_q;
      nw[2][2] = din;

      sum = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            sum = sum + SUM_W'(nw[i][j]) * SUM_W'(K_WEIGHT[i][j]);
         end
      end

      result = border ? nw[1][1]
                      : DATA_W'((sum + SUM_W'(ROUND)) >> NORM_SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         in_col     <= '0;
         in_row     <= '0;
         out_col    <= '0;
         out_row    <= '0;
         win        <= '{default: '0};
         bus.pixel_out  <= '0;
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.out_valid  <= emit;
         bus.frame_done <= 1'b0;

         if (shift) begin
            win <= nw;
         end

         if (emit) begin
            bus.pixel_out <= result;
            if (out_col == LAST_COL) begin
               out_col <= '0;
               out_row <= (out_row == LAST_ROW) ? '0 : out_row + ROW_W'(1);
            end else begin
               out_col <= out_col + COL_W'(1);
            end
         end

         if (accept) begin
            if (in_col == LAST_COL) begin
               in_col <= '0;
               in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
            end else begin
               in_col <= in_col + COL_W'(1);
            end
         end

         case (state)
            IDLE:  if (accept) state <= FILL;
            // The (IMG_WIDTH+1)th pixel sits at row 1, column 0.
            FILL:  if (accept && in_row == ROW_W'(1) && in_col == '0) state <= RUN;
            RUN:   if (accept && in_row == LAST_ROW && in_col == LAST_COL) state <= FLUSH;
            FLUSH: if (out_row == LAST_ROW && out_col == LAST_COL) state <= DONE;
            DONE: begin
               bus.frame_done <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gaussian_smoother.sv
// Scoreboard bench for gaussian_smoother on 4x4 frames: a reference model fills
// an expected-pixel queue per frame and a negedge monitor pops and compares.
module tb_gaussian_smoother;

   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   gaussian_smoother_if #(.DATA_W(8)) bus ();

   gaussian_smoother #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int img [N];
   int exp_q [$];
   int frame_outs = 0;
   int total_outs = 0;
   int done_count = 0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: borders copy the input, interior is the weighted mean rounded half-up.
   function automatic int model_pixel(input int r, input int c);
      int s;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return img[r * W + c];
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * img[(r + dr) * W + (c + dc)];
      return (s + 8) / 16;
   endfunction

   task automatic push_frame();
      for (int i = 0; i < N; i++) exp_q.push_back(model_pixel(i / W, i % W));
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) img[i] = v;
   endtask

   task automatic fill_impulse();
      fill_const(0);
      img[1 * W + 1] = 160;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: enb always high (latency checked), 1: pattern 1,0,0, 2: random stalls.
   task automatic drive_frame(input int mode, input int count);
      for (int k = 0; k < count; k++) begin
         int stalls;
         int held;
         stalls = 0;
         if (k > 0) stalls = (mode == 1) ? 2 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s < stalls; s++) begin
            held = int'(bus.pixel_out);
            bus.enb      = 1'b0;
            bus.pixel_in = 8'($urandom_range(0, 255));
            tick();
            check($sformatf("stall_valid_k%0d", k), int'(bus.out_valid), 0);
            check($sformatf("stall_hold_k%0d", k), int'(bus.pixel_out), held);
         end
         bus.enb      = 1'b1;
         bus.pixel_in = 8'(img[k]);
         tick();
         if (mode == 0) check($sformatf("latency_valid_k%0d", k), int'(bus.out_valid), int'(k >= W + 1));
      end
      bus.enb = 1'b0;
   endtask

   // Waits through FLUSH/DONE, optionally offering the next frame's first pixel.
   task automatic wait_done(input bit hold, input int next_pix);
      bus.enb      = hold;
      bus.pixel_in = 8'(next_pix);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (bus.frame_done) return;
      end
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: no frame_done within 200 cycles");
   endtask

   task automatic start_test();
      frame_outs = 0;
      total_outs = 0;
      done_count = 0;
   endtask

   task automatic end_test(input string name, input int exp_outs, input int exp_done);
      bus.enb = 1'b0;
      repeat (3) tick();
      check({name, "_queue_left"}, exp_q.size(), 0);
      check({name, "_outputs"}, total_outs, exp_outs);
      check({name, "_frame_done"}, done_count, exp_done);
   endtask

   always @(negedge clk) begin
      int e;
      if (!reset) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0d, expected no output", bus.pixel_out);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("pixel_%0d", total_outs), int'(bus.pixel_out), e);
            end
            frame_outs++;
            total_outs++;
         end
         if (bus.frame_done) begin
            check("outputs_per_frame", frame_outs, N);
            check("done_without_valid", int'(bus.out_valid), 0);
            frame_outs = 0;
            done_count++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.enb      = 1'b0;
      bus.pixel_in = '0;
      repeat (3) tick();
      check("reset_pixel_out", int'(bus.pixel_out), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_frame_done", int'(bus.frame_done), 0);
      reset = 1'b0;
      tick();

      // Constant frame with first-output latency.
      start_test();
      fill_const(100);
      push_frame();
      drive_frame(0, N);
      wait_done(1'b0, 0);
      end_test("const100", N, 1);

      // Impulse response.
      start_test();
      fill_impulse();
      push_frame();
      drive_frame(0, N);
      wait_done(1'b0, 0);
      end_test("impulse", N, 1);

      // Full-scale frame: rounding and sum width.
      start_test();
      fill_const(255);
      push_frame();
      drive_frame(0, N);
      wait_done(1'b0, 0);
      end_test("full_scale", N, 1);

      // Impulse with enb 1,0,0 pattern and a flush under enb=0.
      start_test();
      fill_impulse();
      push_frame();
      drive_frame(1, N);
      wait_done(1'b0, 0);
      end_test("impulse_stall", N, 1);

      // Reset after 9 pixels, then a clean constant-50 frame.
      start_test();
      fill_random();
      push_frame();
      drive_frame(0, 9);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      start_test();
      check("midreset_out_valid", int'(bus.out_valid), 0);
      check("midreset_frame_done", int'(bus.frame_done), 0);
      check("midreset_pixel_out", int'(bus.pixel_out), 0);
      fill_const(50);
      push_frame();
      drive_frame(0, N);
      wait_done(1'b0, 0);
      end_test("after_reset", N, 1);

      // Back-to-back frames: the next first pixel is offered through FLUSH/DONE.
      start_test();
      fill_random();
      push_frame();
      drive_frame(0, N);
      fill_random();
      push_frame();
      wait_done(1'b1, img[0]);
      drive_frame(0, N);
      wait_done(1'b0, 0);
      end_test("back_to_back", 2 * N, 2);

      // Random frames with random stalls.
      start_test();
      for (int f = 0; f < 3; f++) begin
         fill_random();
         push_frame();
         drive_frame(2, N);
         wait_done(1'b0, 0);
      end
      end_test("random_stall", 3 * N, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gaussian_smoother.md
Name: gaussian_smoother

Overview:
- Streaming 3x3 Gaussian smoothing stage that sits directly upstream of the edge detection block.
- Accepts one 8-bit raster-order pixel per enabled clock.
- Emits one smoothed 8-bit pixel per valid output in the same raster order, so the output drives the edge detector's pixel input unchanged.
- Handles frame fill, border pixels and end-of-frame flush internally, and pulses frame_done once per frame.

Parameters:
- IMG_WIDTH, 128, pixels per row (>=3)
- IMG_HEIGHT, 128, rows per frame (>=3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  input  1  single system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears state, counters and outputs
- enb  input  1  pixel_in is accepted on a rising edge when enb=1 and state is IDLE, FILL or RUN
- pixel_in  input  DATA_W  raster-order input pixel
- pixel_out  output  DATA_W  smoothed pixel, registered
- out_valid  output  1  pixel_out holds a new pixel this cycle
- frame_done  output  1  one-cycle pulse after the last output pixel of a frame

Behaviour:
- Reset values: pixel_out=0, out_valid=0, frame_done=0, state=IDLE, all row/col counters=0. Reset has priority over every other event, including mid-frame and mid-flush. Line-buffer contents are don't-care after reset.
- Kernel is [1 2 1; 2 4 2; 1 2 1].
  - Sum width is 12 bits; maximum is 16*255=4080.
  - pixel_out=(sum+8)>>4, round-half-up. Maximum result is 255, so no saturation is needed.
- Border pixels pass through unchanged. A border pixel has row 0, row H-1, col 0 or col W-1, and its output equals the input pixel at the same position.
- Storage:
  - Two line buffers of IMG_WIDTH pixels each.
  - One 3x3 window register.
- Output for centre (r,c) is produced when input (r+1,c+1) is accepted, or during flush when no such input exists.
- FSM states and transitions:
  - IDLE: first accepted pixel goes to FILL.
  - FILL: accepts the first IMG_WIDTH+1 pixels and produces no outputs. When the (IMG_WIDTH+1)th pixel is accepted, move to RUN.
  - RUN: each accepted pixel produces exactly one output. out_valid goes high on the next clock and pixel_out is the result for the output counter position. Accepting pixel (H-1,W-1) moves the FSM to FLUSH.
  - FLUSH: enb and pixel_in are ignored. Emits the remaining IMG_WIDTH+1 outputs, one per clock with out_valid high every cycle; all of them are border pixels, read from the line buffers and window. After the last one, move to DONE.
  - DONE: frame_done=1 for exactly one cycle, out_valid=0, then return to IDLE.
- Each frame produces exactly IMG_WIDTH*IMG_HEIGHT outputs, in raster order.
- Stall: enb=0 in FILL or RUN means no pixel is accepted, no counter advances, out_valid=0 next cycle, and pixel_out holds its last value.
- Latency:
  - A RUN-state output appears one clock after the accepting edge.
  - The first output appears one clock after the (IMG_WIDTH+2)th accepted pixel.
- Wrap-around: the column counter wraps W-1→0 and increments the row counter. The row counter wraps to 0 at frame end.
- Back-to-back frames: a pixel arriving while the FSM is in FLUSH or DONE is not accepted; upstream must hold it until IDLE. The first accepted pixel in IDLE starts the new frame with a clean window.

Decomposition:
- Shared package holds:
  - kernel weights
  - SUM_W=12 and ROUND=8
  - FSM state encoding (IDLE, FILL, RUN, FLUSH, DONE)
- One natural sub-module, smoother_line_buffer:
  - IMG_WIDTH-deep, DATA_W-wide delay line with a shift enable.
  - Instantiated twice in a cascade.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, constant 100 frame, enb held high → 16 outputs, all 100; first out_valid one clock after the 6th accepted pixel; frame_done pulses once after the 16th output.
- 4x4 frame of zeros with a single 160 at (1,1) → outputs (1,1)=40, (1,2)=20, (2,1)=20, (2,2)=10, all border outputs 0.
- 4x4 frame of all 255 → every output 255, confirming no overflow and correct rounding.
- Same impulse frame with enb toggling 1,0,0,1… → identical 16-value output sequence; out_valid never high the cycle after a stalled edge; FLUSH completes with enb=0.
- Reset asserted for one clock in the middle of frame 1 (after 9 pixels), then a full constant-50 frame → out_valid=0 and frame_done=0 right after reset; exactly 16 outputs of 50; a single frame_done.
- Two back-to-back 4x4 frames with enb high throughout → pixels offered during FLUSH/DONE are not accepted; 32 outputs total; two frame_done pulses; second frame's results are not corrupted by first-frame data.
